// File: rtl/kamus_pkg.sv
// Shared types and default geometry for the kamus L1 data cache.
package kamus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } l1d_state_e;

  localparam int L1D_NUM_LINES  = 64;
  localparam int L1D_LINE_WORDS = 4;

endpackage

// File: rtl/kamus_l1d_data_ram.sv
// Word-wide data array of the L1D: combinational read port, synchronous write port.
module kamus_l1d_data_ram
  import kamus_pkg::*;
#(
  parameter int DEPTH = L1D_NUM_LINES * L1D_LINE_WORDS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Array contents carry no reset; validity is tracked by the cache top level.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kamus_l1d_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a
// req/gnt/rvalid memory bus and a pipeline stall output.
module kamus_l1d_cache
  import kamus_pkg::*;
#(
  parameter int NUM_LINES  = L1D_NUM_LINES,
  parameter int LINE_WORDS = L1D_LINE_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        l1d_rd_en_i,
  input  logic        l1d_wr_en_i,
  input  logic [31:0] l1d_addr_i,
  input  logic [31:0] l1d_wr_data_i,
  output logic [31:0] l1d_rd_data_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(NUM_LINES);
  localparam int TAGW = 30 - OFF - IDX;
  localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);

  logic [OFF-1:0]  offset;
  logic [IDX-1:0]  index;
  logic [TAGW-1:0] tag;
  logic [1:0]      unused_byte_bits;

  l1d_state_e      state_q, state_d;
  logic [OFF-1:0]  req_cnt_q, rsp_cnt_q;
  logic            req_all_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAGW-1:0] tag_q [NUM_LINES];

  logic            hit;
  logic            fill_beat;
  logic            fill_last;
  logic            ram_we;
  logic [IDX+OFF-1:0] ram_waddr;
  logic [31:0]     ram_wdata;

  assign offset           = l1d_addr_i[OFF+1:2];
  assign index            = l1d_addr_i[OFF+IDX+1:OFF+2];
  assign tag              = l1d_addr_i[31:OFF+IDX+2];
  assign unused_byte_bits = l1d_addr_i[1:0];

  assign hit       = valid_q[index] && (tag_q[index] == tag);
  assign fill_beat = (state_q == REFILL) && mem_rvalid_i;
  assign fill_last = fill_beat && (rsp_cnt_q == LAST_WORD);

  // Next-state, stall, bus drive and data-array write port selection.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    ram_we      = 1'b0;
    ram_waddr   = {index, offset};
    ram_wdata   = l1d_wr_data_i;
    case (state_q)
      IDLE: begin
        if (l1d_wr_en_i) begin
          stall_o = 1'b1;
          state_d = WRITE;
        end else if (l1d_rd_en_i && !hit) begin
          stall_o = 1'b1;
          state_d = REFILL;
        end
      end
      WRITE: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {l1d_addr_i[31:2], 2'b00};
        mem_wdata_o = l1d_wr_data_i;
        if (mem_gnt_i) begin
          ram_we  = hit;
          state_d = DONE;
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = !req_all_q;
        mem_addr_o = {tag, index, req_cnt_q, 2'b00};
        if (mem_rvalid_i) begin
          ram_we    = 1'b1;
          ram_waddr = {index, rsp_cnt_q};
          ram_wdata = mem_rdata_i;
          if (rsp_cnt_q == LAST_WORD) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Refill request/response beat counters; cleared whenever no refill is active.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      req_all_q <= 1'b0;
    end else if (state_q == REFILL) begin
      if (mem_req_o && mem_gnt_i) begin
        req_cnt_q <= req_cnt_q + OFF'(1);
        if (req_cnt_q == LAST_WORD) begin
          req_all_q <= 1'b1;
        end
      end
      if (mem_rvalid_i) begin
        rsp_cnt_q <= rsp_cnt_q + OFF'(1);
      end
    end else begin
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      req_all_q <= 1'b0;
    end
  end

  // Valid bits: dropped on the first refill beat, set again on the last one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (fill_beat) begin
      if (rsp_cnt_q == '0) begin
        valid_q[index] <= 1'b0;
      end
      if (fill_last) begin
        valid_q[index] <= 1'b1;
      end
    end
  end

  // Tag array is only meaningful under a set valid bit, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (fill_last) begin
      tag_q[index] <= tag;
    end
  end

  kamus_l1d_data_ram #(
    .DEPTH(NUM_LINES * LINE_WORDS),
    .AW   (IDX + OFF)
  ) u_data_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i({index, offset}),
    .rdata_o(l1d_rd_data_o)
  );

endmodule

// File: tb/tb_kamus_l1d_cache.sv
// Self-checking bench for kamus_l1d_cache: emulated memory bus plus a
// line-level reference model of cache residency and memory contents.
module tb_kamus_l1d_cache;

  localparam int NL         = 64;
  localparam int LW         = 4;
  localparam int LINE_BYTES = LW * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata, rd_data;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  bit          rand_bus = 1'b0;
  int          rvalid_cnt = 0;
  logic [31:0] read_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] pend_q[$];
  logic [31:0] bus_mem [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  bit          ref_valid [NL];
  int unsigned ref_tag [NL];

  kamus_l1d_cache #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .l1d_rd_en_i  (rd_en),
    .l1d_wr_en_i  (wr_en),
    .l1d_addr_i   (addr),
    .l1d_wr_data_i(wdata),
    .l1d_rd_data_o(rd_data),
    .stall_o      (stall),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Power-on contents of backing memory, identical for bus and reference.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Reference: returns whether the access hits, then applies its effect.
  function automatic bit ref_access(input bit rd, input bit wr, input logic [31:0] a,
                                    input logic [31:0] d);
    int unsigned idx = (a / LINE_BYTES) % NL;
    int unsigned tg  = a / (LINE_BYTES * NL);
    bit h = ref_valid[idx] && (ref_tag[idx] == tg);
    if (wr) begin
      ref_mem[{a[31:2], 2'b00}] = d;
    end else if (rd && !h) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
    end
    return h;
  endfunction

  // Memory bus emulation: gnt and in-order rvalid driven at the falling edge.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (pend_q.size() > 0 && (!rand_bus || $urandom_range(0, 9) < 7)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = bus_read(pend_q.pop_front());
        rvalid_cnt++;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
      if (mem_req === 1'b1 && (!rand_bus || $urandom_range(0, 9) < 6)) begin
        mem_gnt = 1'b1;
        if (mem_we) begin
          bus_mem[mem_addr] = mem_wdata;
          wr_addr_log.push_back(mem_addr);
          wr_data_log.push_back(mem_wdata);
        end else begin
          read_log.push_back(mem_addr);
          pend_q.push_back(mem_addr);
        end
      end else begin
        mem_gnt = 1'b0;
      end
    end
  end

  // Global time limit.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one access and hold it until the cache releases the stall.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output logic [31:0] rdata);
    bit timed_out = 1'b0;
    @(negedge clk);
    rd_en = rd; wr_en = wr; addr = a; wdata = d;
    read_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    lat = 0;
    #1;
    while (stall !== 1'b0) begin
      lat++;
      if (lat > 200) begin timed_out = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    rdata = rd_data;
    n_cmp++;
    if (timed_out) begin
      n_err++;
      $display("[TB] FAIL access_timeout: addr %h still stalled after %0d cycles, need release", a, lat);
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'd0; wdata = 32'd0;
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (stall !== 1'b0)      begin n_err++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (mem_req !== 1'b0)    begin n_err++; $display("[TB] FAIL reset_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0)     begin n_err++; $display("[TB] FAIL reset_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'd0)  begin n_err++; $display("[TB] FAIL reset_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'd0) begin n_err++; $display("[TB] FAIL reset_wdata: got %h want 0", mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    go_idle(2);
  endtask

  // Load miss followed by a load; checks latency, burst addresses and data.
  task automatic test_load_miss(input logic [31:0] a);
    int lat; logic [31:0] rdv; bit h;
    logic [31:0] base = a & ~32'(LINE_BYTES - 1);
    $display("[TB] test_load_miss %h", a);
    h = ref_access(1'b1, 1'b0, a, 32'd0);
    do_access(1'b1, 1'b0, a, 32'd0, lat, rdv);
    n_cmp++; if (h)        begin n_err++; $display("[TB] FAIL miss_expected: model reports hit for %h", a); end
    n_cmp++; if (lat != 6) begin n_err++; $display("[TB] FAIL miss_latency: got %0d want 6", lat); end
    n_cmp++;
    if (read_log.size() != LW) begin
      n_err++; $display("[TB] FAIL refill_count: got %0d reads want %0d", read_log.size(), LW);
    end else begin
      for (int i = 0; i < LW; i++) begin
        n_cmp++;
        if (read_log[i] !== base + 32'(4 * i)) begin
          n_err++; $display("[TB] FAIL refill_addr%0d: got %h want %h", i, read_log[i], base + 32'(4 * i));
        end
      end
    end
    n_cmp++; if (wr_addr_log.size() != 0) begin n_err++; $display("[TB] FAIL miss_writes: got %0d want 0", wr_addr_log.size()); end
    n_cmp++; if (rdv !== ref_read(a)) begin n_err++; $display("[TB] FAIL miss_data: got %h want %h", rdv, ref_read(a)); end
  endtask

  // Hits must complete with no stall and no bus traffic.
  task automatic test_load_hit(input logic [31:0] a);
    int lat; logic [31:0] rdv; bit h;
    h = ref_access(1'b1, 1'b0, a, 32'd0);
    do_access(1'b1, 1'b0, a, 32'd0, lat, rdv);
    n_cmp++; if (!h)       begin n_err++; $display("[TB] FAIL hit_expected: model reports miss for %h", a); end
    n_cmp++; if (lat != 0) begin n_err++; $display("[TB] FAIL hit_latency %h: got %0d want 0", a, lat); end
    n_cmp++; if (read_log.size() != 0) begin n_err++; $display("[TB] FAIL hit_reads %h: got %0d want 0", a, read_log.size()); end
    n_cmp++; if (rdv !== ref_read(a)) begin n_err++; $display("[TB] FAIL hit_data %h: got %h want %h", a, rdv, ref_read(a)); end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    test_load_hit(32'h104);
    test_load_hit(32'h108);
    test_load_hit(32'h10C);
    test_load_hit(32'h100);
    go_idle(1);
  endtask

  // Stores (optionally with rd_en also set) produce exactly one bus write.
  task automatic test_store(input logic [31:0] a, input logic [31:0] d, input bit also_rd);
    int lat; logic [31:0] rdv; bit h;
    $display("[TB] test_store %h rd=%0b", a, also_rd);
    h = ref_access(also_rd, 1'b1, a, d);
    do_access(also_rd, 1'b1, a, d, lat, rdv);
    n_cmp++; if (lat != 2) begin n_err++; $display("[TB] FAIL store_latency: got %0d want 2", lat); end
    n_cmp++; if (read_log.size() != 0) begin n_err++; $display("[TB] FAIL store_reads: got %0d want 0", read_log.size()); end
    n_cmp++;
    if (wr_addr_log.size() != 1) begin
      n_err++; $display("[TB] FAIL store_count: got %0d writes want 1", wr_addr_log.size());
    end else begin
      n_cmp++; if (wr_addr_log[0] !== {a[31:2], 2'b00}) begin n_err++; $display("[TB] FAIL store_addr: got %h want %h", wr_addr_log[0], {a[31:2], 2'b00}); end
      n_cmp++; if (wr_data_log[0] !== d) begin n_err++; $display("[TB] FAIL store_data: got %h want %h", wr_data_log[0], d); end
    end
    if (h) test_load_hit(a);
    else   test_load_miss(a);
    go_idle(1);
  endtask

  task automatic test_evict();
    $display("[TB] test_evict");
    test_load_miss(32'h500);
    test_load_miss(32'h100);
    go_idle(1);
  endtask

  // Reset while the third refill beat is on the bus; the line must stay invalid.
  task automatic test_reset_mid_refill();
    int start, k;
    $display("[TB] test_reset_mid_refill");
    start = rvalid_cnt;
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; addr = 32'h900;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (rvalid_cnt - start < 3 && k < 100);
    n_cmp++; if (rvalid_cnt - start != 3) begin n_err++; $display("[TB] FAIL abort_beats: got %0d beats want 3", rvalid_cnt - start); end
    rst_n = 1'b0; rd_en = 1'b0;
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0)   begin n_err++; $display("[TB] FAIL abort_stall: got %b want 0", stall); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("[TB] FAIL abort_req: got %b want 0", mem_req); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (pend_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
    go_idle(3);
    test_load_miss(32'h900);
    test_load_miss(32'h2000);
    go_idle(1);
  endtask

  // Random mix over a few lines with random gnt/rvalid timing.
  task automatic test_random(input int n);
    int lat; logic [31:0] rdv, a, d; bit h, rd, wr; int op;
    $display("[TB] test_random %0d", n);
    rand_bus = 1'b1;
    for (int i = 0; i < n; i++) begin
      a  = 32'($urandom_range(0, 3) * 1024 + $urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4);
      d  = $urandom;
      op = $urandom_range(0, 19);
      rd = (op < 12) || (op == 19);
      wr = (op >= 12);
      h  = ref_access(rd, wr, a, d);
      do_access(rd, wr, a, d, lat, rdv);
      if (wr) begin
        n_cmp++;
        if (wr_addr_log.size() != 1 || read_log.size() != 0) begin
          n_err++; $display("[TB] FAIL rnd_store_traffic %h: got %0d writes %0d reads want 1/0", a, wr_addr_log.size(), read_log.size());
        end else begin
          n_cmp++;
          if (wr_addr_log[0] !== {a[31:2], 2'b00} || wr_data_log[0] !== d) begin
            n_err++; $display("[TB] FAIL rnd_store_beat: got %h/%h want %h/%h", wr_addr_log[0], wr_data_log[0], {a[31:2], 2'b00}, d);
          end
        end
      end else begin
        n_cmp++; if (rdv !== ref_read(a)) begin n_err++; $display("[TB] FAIL rnd_load_data %h: got %h want %h", a, rdv, ref_read(a)); end
        n_cmp++;
        if (read_log.size() != (h ? 0 : LW) || wr_addr_log.size() != 0) begin
          n_err++; $display("[TB] FAIL rnd_load_traffic %h: got %0d reads want %0d (hit=%0b)", a, read_log.size(), h ? 0 : LW, h);
        end
        if (h) begin
          n_cmp++; if (lat != 0) begin n_err++; $display("[TB] FAIL rnd_hit_latency %h: got %0d want 0", a, lat); end
        end
      end
      if ($urandom_range(0, 3) == 0) go_idle(1);
    end
    rand_bus = 1'b0;
    go_idle(3);
  endtask

  initial begin
    test_reset();
    test_load_miss(32'h100);
    go_idle(1);
    test_back_to_back();
    test_store(32'h104, 32'hDEAD_BEEF, 1'b0);
    test_store(32'h2000, 32'h1234_5678, 1'b0);
    test_evict();
    test_store(32'h108, 32'hCAFE_F00D, 1'b1);
    test_reset_mid_refill();
    test_random(150);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kamus_l1d_cache.md
# kamus_l1d_cache

Direct-mapped, write-through, no-write-allocate L1 data cache that consumes the MEM stage's `$L1D` interface (`l1d_addr`, `l1d_wr_en`, `l1d_wr_data`) and returns `l1d_rd_data` combinationally on a hit. Misses and all stores go to the external memory bus through a req/gnt/rvalid handshake. The cache raises `stall_o` so the pipeline holds the EX/MEM register stable until the access completes.

## Interface
Parameters:
- `NUM_LINES`, 64: number of cache lines; power of two.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk_i` in, 1: single core clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `l1d_rd_en_i` in, 1: load access this cycle (from control unit via EX/MEM).
- `l1d_wr_en_i` in, 1: store access this cycle.
- `l1d_addr_i` in, 32: byte address; bits [1:0] are ignored (word access only).
- `l1d_wr_data_i` in, 32: store data, already formatted by the MEM LSU.
- `l1d_rd_data_o` out, 32: word read from the array at `l1d_addr_i`; combinational.
- `stall_o` out, 1: when high, the pipeline must freeze PC, IF/ID, ID/EX and EX/MEM.
- `mem_req_o` out, 1: memory bus request.
- `mem_we_o` out, 1: memory bus write.
- `mem_addr_o` out, 32: word-aligned bus address.
- `mem_wdata_o` out, 32: bus write data.
- `mem_gnt_i` in, 1: request accepted this cycle.
- `mem_rvalid_i` in, 1: read data valid; responses arrive in order.
- `mem_rdata_i` in, 32: bus read data.

## Operation
- Address split: offset = `addr[OFF+1:2]`, index = next `IDX` bits, tag = remaining upper bits. OFF = log2(LINE_WORDS), IDX = log2(NUM_LINES). Defaults: offset [3:2], index [9:4], tag [31:10].
- Hit means `valid[index] && tag_q[index] == tag`.
- FSM states are IDLE, WRITE, REFILL and DONE.
- IDLE:
  - A store goes to WRITE.
  - A load miss goes to REFILL.
  - A load hit stays in IDLE.
  - No access stays in IDLE.
  - If `rd_en` and `wr_en` are both set, store takes priority; the load is ignored.
- WRITE:
  - Drive `mem_req_o=1`, `mem_we_o=1`, `mem_addr_o={addr[31:2],2'b00}`, `mem_wdata_o=l1d_wr_data_i`.
  - On `mem_gnt_i`: if the access is a hit, write the word into the data array. Go to DONE.
  - A store miss does not allocate.
- REFILL:
  - Issue `LINE_WORDS` read requests, `mem_addr_o={tag,index,req_cnt,2'b00}`, with `req_cnt` incrementing on each gnt.
  - Deassert `mem_req_o` once all requests are granted.
  - On each `mem_rvalid_i`, write `mem_rdata_i` to word `rsp_cnt` of the line and increment `rsp_cnt`.
  - When the last response arrives, set `tag_q[index]` and `valid[index]`, then go to DONE.
  - The line is marked invalid on the first refill beat, so a partially filled line is never hit.
- DONE: one cycle with `stall_o=0`, so the pipeline consumes the held access; then go to IDLE unconditionally. Reads return the freshly filled word in this cycle.
- `stall_o = (IDLE && (wr_en || (rd_en && !hit))) || WRITE || REFILL`. It is combinational in IDLE.
- `l1d_rd_data_o` is the data-array word at index/offset, regardless of hit. The MEM stage only samples it when `stall_o=0`.

## Timing
- Reset: state IDLE, all `valid` bits 0, counters 0. Outputs: `mem_req_o=0`, `mem_we_o=0`, `mem_addr_o=0`, `mem_wdata_o=0`, `stall_o=0`. `l1d_rd_data_o` is unspecified until the first fill.
- Load hit: 0 extra cycles.
- Store, with gnt in the first WRITE cycle: 2 stalled cycles + DONE.
- Load miss, with gnt every cycle and rvalid one cycle after each gnt: 1 (IDLE) + LINE_WORDS + 1 stalled cycles, then DONE. That is 6 cycles for the default.
- `mem_req_o` and its address and data stay stable until `mem_gnt_i`.
- Reset asserted mid-REFILL or mid-WRITE: abort immediately. The line being filled stays invalid; late `rvalid` after reset is ignored.
- Counters are `OFF` bits wide; the wrap to 0 after the last beat is intended.

## Structure
- `kamus_pkg` holds `l1d_state_e` (IDLE, WRITE, REFILL, DONE) and the default `L1D_NUM_LINES` / `L1D_LINE_WORDS` constants.
- Sub-module `kamus_l1d_data_ram`: `NUM_LINES*LINE_WORDS` x 32 array with combinational read and synchronous write. Tags and valid bits live in the top level.

## Test plan
- Reset, then load 0x100 → `stall_o` high, 4 reads at 0x100, 0x104, 0x108, 0x10C; in DONE, `l1d_rd_data_o` equals the word returned for 0x100.
- Repeat load 0x104 → hit, `stall_o=0`, data matches the second refill beat, no `mem_req_o`.
- Store 0xDEADBEEF to 0x104 (hit) → one bus write; then load 0x104 hits and returns 0xDEADBEEF.
- Store to 0x2000 (miss) → bus write only; following load 0x2000 misses and refills.
- Load 0x500 (same index as 0x100, different tag) → refill evicts the line; load 0x100 then misses again.
- Deassert `rst_ni` during the third refill beat → FSM in IDLE, `valid` cleared, `mem_req_o=0`; next load of the same line misses.
